// File: rtl/ula32_trace_rec.sv
// Capture buffer for the ula32 ALU datapath: records one packed test-vector word
// per qualified clock, then plays the stored records back one per request.
module ula32_trace_rec #(
   parameter int DEPTH = 32,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          arm,
   input  logic          stop,
   input  logic          cap_valid,
   input  logic [2:0]    ULAcontrole,
   input  logic [31:0]   SrcA,
   input  logic [31:0]   SrcB,
   input  logic          addSub,
   input  logic [31:0]   ULAsaida,
   input  logic          overflow,
   input  logic          zero,
   input  logic          rd_req,
   output logic [101:0]  rd_data,
   output logic          rd_valid,
   output logic          rd_empty,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          busy,
   output logic          done,
   output logic [7:0]    dropped
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, CAP, DONE} state_t;

   state_t        state;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] rd_ptr;
   logic [101:0]  mem [DEPTH];
   logic [101:0]  record;
   logic          wr_en;
   logic          rd_en;
   logic          last_write;

   always_comb begin
      record     = {ULAcontrole, SrcA, SrcB, addSub, ULAsaida, overflow, zero};
      wr_en      = (state == CAP) && cap_valid;
      last_write = wr_en && (count == LAST_C);
      // arm in DONE pre-empts any read in the same cycle
      rd_en      = (state == DONE) && !arm && rd_req && (rd_ptr < count);
   end

   assign busy     = (state == CAP);
   assign done     = (state == DONE);
   assign full     = (count == DEPTH_C);
   assign rd_empty = done && (rd_ptr == count);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         dropped  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         case (state)
            IDLE: begin
               if (arm) begin
                  state   <= CAP;
                  wr_ptr  <= '0;
                  rd_ptr  <= '0;
                  count   <= '0;
                  dropped <= '0;
               end
            end
            CAP: begin
               if (wr_en) begin
                  count <= count + CW'(1);
                  // hold wr_ptr on the full write so it never passes DEPTH-1
                  if (!last_write)
                     wr_ptr <= wr_ptr + AW'(1);
               end
               if (stop || last_write)
                  state <= DONE;
            end
            DONE: begin
               if (arm) begin
                  state   <= CAP;
                  wr_ptr  <= '0;
                  rd_ptr  <= '0;
                  count   <= '0;
                  dropped <= '0;
               end else begin
                  if (rd_en)
                     rd_ptr <= rd_ptr + CW'(1);
                  if (cap_valid && (dropped != 8'hFF))
                     dropped <= dropped + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= record;
   end

   always_ff @(posedge clk) begin
      if (!rst)
         rd_data <= '0;
      else if (rd_en)
         rd_data <= mem[rd_ptr[AW-1:0]];
   end

endmodule

// File: tb/tb_ula32_trace_rec.sv
// Directed bench for ula32_trace_rec: capture, readout, fill, re-arm and drop
// counting, with expected record words packed by the bench itself.
module tb_ula32_trace_rec;

   localparam int DEPTH = 32;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst, arm, stop, cap_valid, rd_req;
   logic [2:0]    ULAcontrole;
   logic [31:0]   SrcA, SrcB, ULAsaida;
   logic          addSub, overflow, zero;
   logic [101:0]  rd_data;
   logic          rd_valid, rd_empty, full, busy, done;
   logic [CW-1:0] count;
   logic [7:0]    dropped;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [101:0] v0, v1, v2;

   ula32_trace_rec #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk(clk), .rst(rst), .arm(arm), .stop(stop), .cap_valid(cap_valid),
      .ULAcontrole(ULAcontrole), .SrcA(SrcA), .SrcB(SrcB), .addSub(addSub),
      .ULAsaida(ULAsaida), .overflow(overflow), .zero(zero),
      .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
      .rd_empty(rd_empty), .count(count), .full(full), .busy(busy),
      .done(done), .dropped(dropped)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [101:0] got, input logic [101:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [101:0] r);
      ULAcontrole = r[101:99];
      SrcA        = r[98:67];
      SrcB        = r[66:35];
      addSub      = r[34];
      ULAsaida    = r[33:2];
      overflow    = r[1];
      zero        = r[0];
   endtask

   function automatic logic [101:0] fill_vec(input int unsigned k);
      logic [31:0] kk, a, b;
      kk = k;
      a  = 32'h1000_0000 + kk;
      b  = ~kk;
      return {kk[2:0], a, b, kk[0], a ^ b, kk[1], kk[2]};
   endfunction

   initial begin
      v0 = {3'b010, 32'd5,          32'd3, 1'b0, 32'd8,          1'b0, 1'b0};
      v1 = {3'b010, 32'h7FFF_FFFF,  32'd1, 1'b0, 32'h8000_0000,  1'b1, 1'b0};
      v2 = {3'b110, 32'd4,          32'd4, 1'b1, 32'd0,          1'b0, 1'b1};

      rst = 1'b0; arm = 1'b1; stop = 1'b0; cap_valid = 1'b0; rd_req = 1'b0;
      drive('0);
      tick(); tick();
      check("rst_rd_data",  rd_data,  '0);
      check("rst_rd_valid", rd_valid, '0);
      check("rst_count",    count,    '0);
      check("rst_full",     full,     '0);
      check("rst_busy",     busy,     '0);
      check("rst_done",     done,     '0);
      check("rst_dropped",  dropped,  '0);
      check("rst_rd_empty", rd_empty, '0);

      // arm, three transactions, stop
      rst = 1'b1; arm = 1'b1;
      tick();
      arm = 1'b0;
      check("arm_busy", busy, 1);
      cap_valid = 1'b1;
      drive(v0); tick();
      check("cap_count1", count, 1);
      drive(v1); tick();
      drive(v2); tick();
      cap_valid = 1'b0; stop = 1'b1;
      tick();
      stop = 1'b0;
      check("stop_count", count, 3);
      check("stop_done",  done,  1);
      check("stop_busy",  busy,  0);
      check("stop_empty", rd_empty, 0);

      rd_req = 1'b1;
      tick(); check("rd0_valid", rd_valid, 1); check("rd0_data", rd_data, v0);
      tick(); check("rd1_valid", rd_valid, 1); check("rd1_data", rd_data, v1);
      tick(); check("rd2_valid", rd_valid, 1); check("rd2_data", rd_data, v2);
      tick(); check("rd3_valid", rd_valid, 0); check("rd3_hold", rd_data, v2);
      check("rd3_empty", rd_empty, 1);
      rd_req = 1'b0;

      // re-arm mid-readout
      arm = 1'b1; tick(); arm = 1'b0;
      cap_valid = 1'b1;
      drive(v1); tick();
      drive(v2); tick();
      drive(v0); tick();
      cap_valid = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
      rd_req = 1'b1; tick(); rd_req = 1'b0;
      check("rearm_rd0", rd_data, v1);
      cap_valid = 1'b1; tick(); cap_valid = 1'b0;
      check("rearm_drop1", dropped, 1);
      arm = 1'b1; rd_req = 1'b1; cap_valid = 1'b1;
      tick();
      arm = 1'b0; rd_req = 1'b0; cap_valid = 1'b0;
      check("rearm_valid",   rd_valid, 0);
      check("rearm_count",   count,    0);
      check("rearm_dropped", dropped,  0);
      check("rearm_busy",    busy,     1);

      // stop together with the third capture
      cap_valid = 1'b1;
      drive(v2); tick();
      drive(v1); tick();
      drive(v0); stop = 1'b1; tick();
      cap_valid = 1'b0; stop = 1'b0;
      check("stopcap_count", count, 3);
      check("stopcap_done",  done,  1);
      rd_req = 1'b1;
      tick(); tick(); tick();
      rd_req = 1'b0;
      check("stopcap_rd2", rd_data, v0);

      // fill: 40 cap_valid cycles, the first coincides with arm
      for (int unsigned k = 0; k < 40; k++) begin
         arm = (k == 0);
         cap_valid = 1'b1;
         drive(fill_vec(k));
         tick();
         if (k == 31) begin
            check("fill_count31", count, 31);
            check("fill_full31",  full,  0);
         end
         if (k == 32) begin
            check("fill_full",  full,  1);
            check("fill_done",  done,  1);
            check("fill_busy",  busy,  0);
            check("fill_count", count, DEPTH);
         end
      end
      arm = 1'b0; cap_valid = 1'b0;
      check("fill_dropped", dropped, 7);
      rd_req = 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         tick();
         check($sformatf("fill_rd%0d", i), rd_data, fill_vec(i + 1));
      end
      rd_req = 1'b0;
      check("fill_empty", rd_empty, 1);

      // drop counter saturation
      cap_valid = 1'b1;
      for (int unsigned i = 0; i < 100; i++) tick();
      check("drop_107", dropped, 107);
      for (int unsigned i = 0; i < 200; i++) tick();
      cap_valid = 1'b0;
      check("drop_sat", dropped, 255);

      // reset aborts a capture
      arm = 1'b1; tick(); arm = 1'b0;
      cap_valid = 1'b1; drive(v0); tick();
      rst = 1'b0; tick(); rst = 1'b1; cap_valid = 1'b0;
      check("abort_busy",  busy,  0);
      check("abort_count", count, 0);
      check("abort_done",  done,  0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
